ssram_stream_reader: RTL

Read-side streaming engine for the dual-port synchronous SRAM in the RAM/DMA custom-instruction block. On a start command it walks a contiguous (wrapping) address range on one SRAM port, absorbs the memory's one-cycle registered read latency, and presents the words as a valid/ready stream with a last-beat marker. It sits between the SRAM's port B and the DMA bus-write path, and sustains one word per cycle when the sink never stalls.

---
 rtl/ssram_stream_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/ssram_stream_reader.sv
// Streams a contiguous, wrapping range of SRAM words out as a valid/ready stream.
// A 2-entry FIFO absorbs the one-cycle read latency, and a credit check on issue keeps it full-rate.
module ssram_stream_reader #(
  parameter int unsigned Bitwidth    = 32,
  parameter int unsigned NrOfEntries = 512,
  localparam int unsigned AddrW      = $clog2(NrOfEntries),
  localparam int unsigned LenW       = AddrW + 1
) (
  input  logic                clock_i,
  input  logic                n_reset_i,
  input  logic                start_i,
  input  logic [AddrW-1:0]    start_address_i,
  input  logic [LenW-1:0]     length_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [AddrW-1:0]    mem_address_o,
  output logic                mem_write_enable_o,
  input  logic [Bitwidth-1:0] mem_data_i,
  output logic [Bitwidth-1:0] stream_data_o,
  output logic                stream_valid_o,
  input  logic                stream_ready_i,
  output logic                stream_last_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic [LenW-1:0]     remaining_q;
  logic                in_flight_q, in_flight_last_q;
  logic [Bitwidth-1:0] fifo_data_q [2];
  logic [1:0]          fifo_last_q;
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q;
  logic                done_q;

  logic       pop, push, issue, finish, head_last;
  logic [2:0] occupancy;

  always_comb begin
    pop       = (count_q != 2'd0) & stream_ready_i;
    push      = in_flight_q;
    head_last = fifo_last_q[rd_ptr_q];
    // Words buffered or in flight after this edge's pop; issue only if a slot stays free.
    occupancy = 3'(count_q) + 3'(in_flight_q) - 3'(pop);
    issue     = (state_q == StRun) && (remaining_q != '0) && (occupancy < 3'd2);
    // Second term only fires for a zero-length transfer.
    finish    = (state_q == StRun) &&
                ((pop && head_last) ||
                 ((remaining_q == '0) && (count_q == 2'd0) && !in_flight_q));
    addr_d    = (addr_q == AddrW'(NrOfEntries - 1)) ? '0 : addr_q + AddrW'(1);
  end

  always_ff @(posedge clock_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q          <= StIdle;
      addr_q           <= '0;
      remaining_q      <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      fifo_data_q[0]   <= '0;
      fifo_data_q[1]   <= '0;
      fifo_last_q      <= '0;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
      count_q          <= '0;
      done_q           <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      in_flight_q <= issue;
      if (issue) begin
        in_flight_last_q <= (remaining_q == LenW'(1));
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_data_i;
        fifo_last_q[wr_ptr_q] <= in_flight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StRun;
            addr_q      <= start_address_i;
            remaining_q <= length_i;
          end
        end
        StRun: begin
          if (issue) begin
            addr_q      <= addr_d;
            remaining_q <= remaining_q - LenW'(1);
          end
          if (finish) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy_o             = (state_q == StRun);
    done_o             = done_q;
    mem_address_o      = addr_q;
    mem_write_enable_o = 1'b0;
    stream_valid_o     = (count_q != 2'd0);
    stream_data_o      = fifo_data_q[rd_ptr_q];
    stream_last_o      = stream_valid_o & head_last;
  end

  fifo_no_overflow_a : assert property (@(posedge clock_i) disable iff (!n_reset_i)
    !(push && !pop && (count_q == 2'd2)));

endmodule
